// File: rtl/hazard_sb_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_sb_unit_pkg
// Shared types for the hazard controller:
//   hazard_state_t - controller FSM state (RUN / DWAIT / REDIR), 2-bit encoded
//   hazard_cause_t - which performance counter a cycle is charged to
//   stage_ctrl_t   - bundle of all stage enables and flushes driven by the unit
// Canned stage_ctrl_t values for every output rule are provided so the top
// level reads as a priority list rather than a wall of bit assignments.
// -----------------------------------------------------------------------------
package hazard_sb_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_REDIR = 2'd2
    } hazard_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_STALL = 2'd1,
        CAUSE_FLUSH = 2'd2
    } hazard_cause_t;

    // Field order is MSB first, so a 7-bit literal reads
    // {pc, ifid, idex, exmem, ifid_flush, idex_flush, memwb_flush}.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_RUN    = 7'b1111_000; // normal advance
    localparam stage_ctrl_t CTRL_DWAIT  = 7'b0000_001; // freeze, bubble into WB
    localparam stage_ctrl_t CTRL_BRANCH = 7'b1111_110; // kill IF and ID
    localparam stage_ctrl_t CTRL_JUMP   = 7'b1111_100; // kill IF only
    localparam stage_ctrl_t CTRL_RAW    = 7'b0011_010; // hold IF/ID, bubble into EX
    localparam stage_ctrl_t CTRL_IMISS  = 7'b0111_100; // hold PC, bubble into ID
    localparam stage_ctrl_t CTRL_RESET  = 7'b0000_111; // everything held and flushed

endpackage

// File: rtl/hazard_sb_unit_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_sb_unit_scoreboard
// Per-register countdown for results of the long-latency unit (mult/div).
// A register is busy while its counter is nonzero; register 0 has no entry
// and is never busy.
// Ports:
//   CLK, nRST  - clock (rising edge), asynchronous active-low reset
//   set_en     - load LONG_LAT into the entry of set_rd this edge
//   set_rd     - destination register of the issuing long op
//   dec_en     - pipeline advancing past EX: all nonzero entries count down
//   busy       - one bit per architectural register, bit 0 tied low
// -----------------------------------------------------------------------------
module hazard_sb_unit_scoreboard #(
    parameter int REG_W    = 5,
    parameter int LONG_LAT = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     set_en,
    input  logic [REG_W-1:0]         set_rd,
    input  logic                     dec_en,
    output logic [(1<<REG_W)-1:0]    busy
);

    localparam int NREG = 1 << REG_W;
    localparam int CW   = $clog2(LONG_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(LONG_LAT);

    logic [CW-1:0] cnt_q [1:NREG-1];
    logic [CW-1:0] cnt_d [1:NREG-1];

    // A new issue to the same register restarts its countdown, so the set
    // branch is checked before the decrement.
    // NOTE: every variable in an always_comb gets a value on every path
    // (here by starting from the current count), otherwise a latch is inferred.
    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (set_en && (set_rd == REG_W'(r))) begin
                cnt_d[r] = LAT;
            end else if (dec_en && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
        end
    end

    // NOTE: this array is state the pipeline depends on (a stale nonzero
    // entry would stall forever), so unlike a data RAM it must be reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < NREG; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

endmodule

// File: rtl/hazard_sb_unit.sv
// -----------------------------------------------------------------------------
// hazard_sb_unit
// Hazard controller for the pipelined MIPS core. Drives every pipeline stage
// enable and flush from a fixed priority list: data-memory wait, taken branch,
// jump, held redirect, RAW/WAW hazard, instruction miss, normal advance.
// Ports:
//   CLK, nRST                 - clock, asynchronous active-low reset
//   ifid_src/ifid_src_used    - ID source registers (port i at [i*REG_W +: REG_W])
//   ifid_long/ifid_long_rd    - long op in ID and its destination
//   ifid_jump                 - jump resolved in ID
//   idex_rt/idex_dren         - load in EX and its destination
//   ex_branch_taken           - branch resolved taken in EX
//   ihit, mem_req, dhit       - memory handshakes
//   pc_en..exmem_en           - stage register enables
//   ifid/idex/memwb_flush     - load a bubble into that stage register
//   state                     - 0 RUN, 1 DWAIT, 2 REDIR
//   stall_cnt, flush_cnt      - saturating performance counters
// -----------------------------------------------------------------------------
module hazard_sb_unit
    import hazard_sb_unit_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int SRC_PORTS = 2,
    parameter int LONG_LAT  = 4,
    parameter int CNT_W     = 32
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [SRC_PORTS*REG_W-1:0]   ifid_src,
    input  logic [SRC_PORTS-1:0]         ifid_src_used,
    input  logic [REG_W-1:0]             ifid_long_rd,
    input  logic                         ifid_long,
    input  logic                         ifid_jump,
    input  logic [REG_W-1:0]             idex_rt,
    input  logic                         idex_dren,
    input  logic                         ex_branch_taken,
    input  logic                         ihit,
    input  logic                         mem_req,
    input  logic                         dhit,
    output logic                         pc_en,
    output logic                         ifid_en,
    output logic                         idex_en,
    output logic                         exmem_en,
    output logic                         ifid_flush,
    output logic                         idex_flush,
    output logic                         memwb_flush,
    output logic [1:0]                   state,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             flush_cnt
);

    hazard_state_t          state_q, state_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;
    logic [(1<<REG_W)-1:0]  busy;
    logic                   raw, waw, dwait, redirect;
    stage_ctrl_t            ctrl, ctrl_out;
    hazard_cause_t          cause;
    logic                   sb_set, sb_dec;

    // ---------------------------------------------------------------- hazards
    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < SRC_PORTS; i++) begin
            if (ifid_src_used[i] && (ifid_src[i*REG_W +: REG_W] != '0) &&
                (busy[ifid_src[i*REG_W +: REG_W]] ||
                 (idex_dren && (idex_rt == ifid_src[i*REG_W +: REG_W])))) begin
                raw = 1'b1;
            end
        end
    end

    // A second long op to a register still in flight must wait, or the older
    // result would overwrite the newer one.
    assign waw   = ifid_long && (ifid_long_rd != '0) && busy[ifid_long_rd];
    assign dwait = mem_req && !dhit;

    // ------------------------------------------------- output rules and FSM
    always_comb begin
        ctrl     = CTRL_RUN;
        cause    = CAUSE_NONE;
        redirect = 1'b0;

        if (dwait) begin
            ctrl  = CTRL_DWAIT;
            cause = CAUSE_STALL;
        end else if (ex_branch_taken) begin
            ctrl     = CTRL_BRANCH;
            cause    = CAUSE_FLUSH;
            redirect = 1'b1;
        end else if (ifid_jump) begin
            ctrl     = CTRL_JUMP;
            cause    = CAUSE_FLUSH;
            redirect = 1'b1;
        end else if (state_q == ST_REDIR) begin
            // The PC already holds the target; the fetch returning this cycle
            // is for the old stream and is discarded.
            ctrl       = CTRL_JUMP;
            ctrl.pc_en = ihit;
            cause      = CAUSE_FLUSH;
        end else if (raw || waw) begin
            ctrl  = CTRL_RAW;
            cause = CAUSE_STALL;
        end else if (!ihit) begin
            ctrl  = CTRL_IMISS;
            cause = CAUSE_STALL;
        end

        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (dwait) begin
                    state_d = ST_DWAIT;
                end else if (redirect && !ihit) begin
                    state_d = ST_REDIR;
                end
            end
            ST_DWAIT: begin
                if (dhit) state_d = ST_RUN;
            end
            ST_REDIR: begin
                if (ihit) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Reset forces everything held and flushed regardless of inputs.
    assign ctrl_out = nRST ? ctrl : CTRL_RESET;

    assign pc_en       = ctrl_out.pc_en;
    assign ifid_en     = ctrl_out.ifid_en;
    assign idex_en     = ctrl_out.idex_en;
    assign exmem_en    = ctrl_out.exmem_en;
    assign ifid_flush  = ctrl_out.ifid_flush;
    assign idex_flush  = ctrl_out.idex_flush;
    assign memwb_flush = ctrl_out.memwb_flush;

    // -------------------------------------------------------------- scoreboard
    // Only a long op actually entering EX (not replaced by a bubble) claims
    // its destination; occupancy counts down only while EX advances.
    assign sb_set = ifid_long && ctrl_out.idex_en && !ctrl_out.idex_flush &&
                    (ifid_long_rd != '0);
    assign sb_dec = ctrl_out.exmem_en;

    hazard_sb_unit_scoreboard #(
        .REG_W    (REG_W),
        .LONG_LAT (LONG_LAT)
    ) u_scoreboard (
        .CLK    (CLK),
        .nRST   (nRST),
        .set_en (sb_set),
        .set_rd (ifid_long_rd),
        .dec_en (sb_dec),
        .busy   (busy)
    );

    // ---------------------------------------------------------------- counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((cause == CAUSE_STALL) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((cause == CAUSE_FLUSH) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values; blocking here would create races.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sb_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_sb_unit
// Self-checking bench for hazard_sb_unit. A main instance (default parameters)
// is compared every cycle against a timestamp-based reference model; a second
// instance with LONG_LAT=1 and 3-bit counters shares the same inputs and is
// used for latency-1 and counter saturation corners.
// -----------------------------------------------------------------------------
module tb_hazard_sb_unit;

    localparam int REG_W    = 5;
    localparam int LONG_LAT = 4;
    localparam int CNT_W    = 32;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic        CLK;
    logic        nRST;
    logic [9:0]  ifid_src;
    logic [1:0]  ifid_src_used;
    logic [4:0]  ifid_long_rd;
    logic        ifid_long, ifid_jump;
    logic [4:0]  idex_rt;
    logic        idex_dren, ex_branch_taken, ihit, mem_req, dhit;

    logic        pc_en, ifid_en, idex_en, exmem_en;
    logic        ifid_flush, idex_flush, memwb_flush;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;

    logic        pc_en2, ifid_en2, idex_en2, exmem_en2;
    logic        ifid_flush2, idex_flush2, memwb_flush2;
    logic [1:0]  state2;
    logic [2:0]  stall_cnt2, flush_cnt2;

    logic [6:0]  dut_ctrl, dut2_ctrl;
    assign dut_ctrl  = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush};
    assign dut2_ctrl = {pc_en2, ifid_en2, idex_en2, exmem_en2, ifid_flush2, idex_flush2, memwb_flush2};

    hazard_sb_unit #(.REG_W(REG_W), .SRC_PORTS(2), .LONG_LAT(LONG_LAT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ifid_src(ifid_src), .ifid_src_used(ifid_src_used),
        .ifid_long_rd(ifid_long_rd), .ifid_long(ifid_long), .ifid_jump(ifid_jump),
        .idex_rt(idex_rt), .idex_dren(idex_dren), .ex_branch_taken(ex_branch_taken),
        .ihit(ihit), .mem_req(mem_req), .dhit(dhit),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_sb_unit #(.REG_W(REG_W), .SRC_PORTS(2), .LONG_LAT(1), .CNT_W(3)) dut2 (
        .CLK(CLK), .nRST(nRST), .ifid_src(ifid_src), .ifid_src_used(ifid_src_used),
        .ifid_long_rd(ifid_long_rd), .ifid_long(ifid_long), .ifid_jump(ifid_jump),
        .idex_rt(idex_rt), .idex_dren(idex_dren), .ex_branch_taken(ex_branch_taken),
        .ihit(ihit), .mem_req(mem_req), .dhit(dhit),
        .pc_en(pc_en2), .ifid_en(ifid_en2), .idex_en(idex_en2), .exmem_en(exmem_en2),
        .ifid_flush(ifid_flush2), .idex_flush(idex_flush2), .memwb_flush(memwb_flush2),
        .state(state2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // ----------------------------------------------------------------- types
    typedef struct {
        logic [4:0] src0, src1;
        logic [1:0] used;
        logic [4:0] long_rd;
        logic       lng, jump;
        logic [4:0] idex_rt;
        logic       dren, br, ihit, mem_req, dhit;
    } vin_t;

    typedef struct {
        vin_t       in;
        logic [6:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // --------------------------------------------------------- reference model
    // Scoreboard modelled with timestamps: "ticks" counts cycles in which EX
    // advanced; a register is busy until ticks reaches its ready time.
    int     m_state;
    longint m_ticks;
    longint m_ready [32];
    longint m_stall, m_flush;

    function automatic vin_t mk(int s0, int s1, int used, int lrd, int lng, int jump,
                                int rt, int dren, int br, int ih, int mreq, int dh);
        vin_t v;
        v.src0 = 5'(s0);   v.src1 = 5'(s1);  v.used = 2'(used);
        v.long_rd = 5'(lrd); v.lng = 1'(lng); v.jump = 1'(jump);
        v.idex_rt = 5'(rt); v.dren = 1'(dren); v.br = 1'(br);
        v.ihit = 1'(ih); v.mem_req = 1'(mreq); v.dhit = 1'(dh);
        return v;
    endfunction

    function automatic void m_reset();
        m_state = 0;
        m_ticks = 0;
        for (int r = 0; r < 32; r++) m_ready[r] = 0;
        m_stall = 0;
        m_flush = 0;
    endfunction

    function automatic bit m_busy(logic [4:0] r);
        return (r != 0) && (m_ready[r] > m_ticks);
    endfunction

    function automatic int m_rule(vin_t v);
        bit raw, waw;
        logic [4:0] s [2];
        s[0] = v.src0;
        s[1] = v.src1;
        raw = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (v.used[i] && s[i] != 0 && (m_busy(s[i]) || (v.dren && v.idex_rt == s[i])))
                raw = 1'b1;
        end
        waw = v.lng && v.long_rd != 0 && m_busy(v.long_rd);
        if (v.mem_req && !v.dhit) return 1;
        if (v.br)                 return 2;
        if (v.jump)               return 3;
        if (m_state == 2)         return 4;
        if (raw || waw)           return 5;
        if (!v.ihit)              return 6;
        return 7;
    endfunction

    function automatic logic [6:0] m_ctrl(int rule, logic ih);
        case (rule)
            1: return 7'b0000_001;
            2: return 7'b1111_110;
            3: return 7'b1111_100;
            4: return {ih, 6'b111_100};
            5: return 7'b0011_010;
            6: return 7'b0111_100;
            default: return 7'b1111_000;
        endcase
    endfunction

    function automatic void m_update(vin_t v, int rule, logic [6:0] c);
        if (c[3]) m_ticks++;
        if (v.lng && c[4] && !c[1] && v.long_rd != 0) m_ready[v.long_rd] = m_ticks + LONG_LAT;
        if ((rule == 1 || rule == 5 || rule == 6) && m_stall < CNT_MAX) m_stall++;
        if ((rule == 2 || rule == 3 || rule == 4) && m_flush < CNT_MAX) m_flush++;
        case (m_state)
            0: if (rule == 1) m_state = 1;
               else if ((rule == 2 || rule == 3) && !v.ihit) m_state = 2;
            1: if (v.dhit) m_state = 0;
            default: if (v.ihit) m_state = 0;
        endcase
    endfunction

    // ------------------------------------------------------------------ tasks
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vin_t v);
        ifid_src        = {v.src1, v.src0};
        ifid_src_used   = v.used;
        ifid_long_rd    = v.long_rd;
        ifid_long       = v.lng;
        ifid_jump       = v.jump;
        idex_rt         = v.idex_rt;
        idex_dren       = v.dren;
        ex_branch_taken = v.br;
        ihit            = v.ihit;
        mem_req         = v.mem_req;
        dhit            = v.dhit;
    endtask

    // One clock cycle: drive, compare at the falling edge, advance the model.
    // which: 0 model only, 1 also main-instance constant, 2 also second-instance constant.
    task automatic cycle(input vin_t v, input string tag, input int which, input logic [6:0] exp);
        int rule;
        logic [6:0] mc;
        apply(v);
        @(negedge CLK);
        rule = m_rule(v);
        mc   = m_ctrl(rule, v.ihit);
        check({tag, " ctrl vs model"}, dut_ctrl, mc);
        check({tag, " state vs model"}, state, m_state);
        check({tag, " stall_cnt vs model"}, stall_cnt, m_stall);
        check({tag, " flush_cnt vs model"}, flush_cnt, m_flush);
        if (which == 1) check({tag, " ctrl"}, dut_ctrl, exp);
        if (which == 2) check({tag, " ctrl2"}, dut2_ctrl, exp);
        @(posedge CLK);
        m_update(v, rule, mc);
        #1;
    endtask

    task automatic do_reset(input string tag);
        nRST = 1'b0;
        #2;
        m_reset();
        check({tag, " reset ctrl"}, dut_ctrl, 7'b0000_111);
        check({tag, " reset state"}, state, 0);
        check({tag, " reset stall_cnt"}, stall_cnt, 0);
        check({tag, " reset flush_cnt"}, flush_cnt, 0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    // --------------------------------------------------------------- stimulus
    vec_t tbl [15];

    initial begin
        vin_t idle, v;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 7'b1111_000};
        tbl[1]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7'b0111_100};
        tbl[2]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 7'b0000_001};
        tbl[3]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), 7'b1111_000};
        tbl[4]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 7'b1111_110};
        tbl[5]  = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), 7'b1111_100};
        tbl[6]  = '{mk(0, 8, 2, 0, 0, 0, 8, 1, 0, 1, 0, 0), 7'b0011_010};
        tbl[7]  = '{mk(3, 8, 1, 0, 0, 0, 8, 1, 0, 1, 0, 0), 7'b1111_000};
        tbl[8]  = '{mk(0, 0, 3, 0, 0, 0, 0, 1, 0, 1, 0, 0), 7'b1111_000};
        tbl[9]  = '{mk(8, 0, 1, 0, 0, 0, 8, 1, 0, 0, 0, 0), 7'b0011_010};
        tbl[10] = '{mk(8, 0, 1, 0, 0, 0, 8, 1, 1, 1, 0, 0), 7'b1111_110};
        tbl[11] = '{mk(8, 0, 1, 0, 0, 1, 8, 1, 0, 1, 0, 0), 7'b1111_100};
        tbl[12] = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0), 7'b0000_001};
        tbl[13] = '{mk(8, 8, 3, 0, 0, 0, 8, 1, 0, 1, 1, 1), 7'b0011_010};
        tbl[14] = '{mk(8, 9, 3, 0, 0, 0, 7, 1, 0, 1, 0, 0), 7'b1111_000};

        nRST = 1'b0;
        apply(idle);
        do_reset("init");

        // Single-cycle rule priority table
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].in, $sformatf("tbl%0d", i), 1, tbl[i].exp);
        end

        // Load-use: one stall cycle
        do_reset("lu");
        cycle(mk(0, 8, 2, 0, 0, 0, 8, 1, 0, 1, 0, 0), "lu stall", 1, 7'b0011_010);
        cycle(idle, "lu go", 1, 7'b1111_000);
        check("lu stall_cnt", stall_cnt, 1);

        // Long op to r9: consumer stalled cycles 1-4, advances in 5
        do_reset("lo");
        cycle(mk(0, 0, 0, 9, 1, 0, 0, 0, 0, 1, 0, 0), "lo issue", 1, 7'b1111_000);
        for (int c = 1; c <= 4; c++)
            cycle(mk(9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1), $sformatf("lo c%0d", c), 1, 7'b0011_010);
        cycle(mk(9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1), "lo c5", 1, 7'b1111_000);

        // Same with a data wait in cycle 2: advances in cycle 6
        do_reset("lw");
        cycle(mk(0, 0, 0, 9, 1, 0, 0, 0, 0, 1, 0, 0), "lw issue", 1, 7'b1111_000);
        cycle(mk(9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1), "lw c1", 1, 7'b0011_010);
        cycle(mk(9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0), "lw c2", 1, 7'b0000_001);
        for (int c = 3; c <= 5; c++)
            cycle(mk(9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1), $sformatf("lw c%0d", c), 1, 7'b0011_010);
        cycle(mk(9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1), "lw c6", 1, 7'b1111_000);

        // Data wait with a pending taken branch
        do_reset("db");
        for (int c = 0; c < 3; c++)
            cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), $sformatf("db wait%0d", c), 1, 7'b0000_001);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1), "db branch", 1, 7'b1111_110);
        check("db stall_cnt", stall_cnt, 3);
        check("db flush_cnt", flush_cnt, 1);
        check("db state", state, 0);

        // Redirect held across an instruction miss
        do_reset("rd");
        cycle(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "rd jump", 1, 7'b1111_100);
        check("rd state0", state, 2);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rd miss1", 1, 7'b0111_100);
        check("rd state1", state, 2);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rd miss2", 1, 7'b0111_100);
        check("rd state2", state, 2);
        cycle(idle, "rd hit", 1, 7'b1111_100);
        check("rd state after", state, 0);
        check("rd flush_cnt", flush_cnt, 4);
        cycle(idle, "rd run", 1, 7'b1111_000);

        // Register 0 never hazardous; WAW on r5 stalls until free, then reloads
        do_reset("ww");
        cycle(mk(0, 0, 3, 0, 0, 0, 0, 1, 0, 1, 0, 0), "ww r0", 1, 7'b1111_000);
        cycle(mk(0, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0), "ww issue", 1, 7'b1111_000);
        cycle(idle, "ww gap1", 1, 7'b1111_000);
        cycle(idle, "ww gap2", 1, 7'b1111_000);
        cycle(mk(0, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0), "ww stall1", 1, 7'b0011_010);
        cycle(mk(0, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0), "ww stall2", 1, 7'b0011_010);
        cycle(mk(0, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0), "ww reissue", 1, 7'b1111_000);
        for (int c = 1; c <= 4; c++)
            cycle(mk(0, 5, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0), $sformatf("ww use%0d", c), 1, 7'b0011_010);
        cycle(mk(0, 5, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0), "ww use5", 1, 7'b1111_000);

        // Reset in the middle of a data wait with r3 busy
        do_reset("rm");
        cycle(mk(0, 0, 0, 3, 1, 0, 0, 0, 0, 1, 0, 0), "rm issue", 1, 7'b1111_000);
        cycle(idle, "rm idle", 1, 7'b1111_000);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), "rm wait", 1, 7'b0000_001);
        check("rm state dwait", state, 1);
        apply(mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        do_reset("rm mid");
        cycle(mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rm r3 free", 1, 7'b1111_000);

        // LONG_LAT=1 instance: exactly one stall cycle
        do_reset("l1");
        cycle(mk(0, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 0), "l1 issue", 2, 7'b1111_000);
        cycle(mk(4, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0), "l1 stall", 2, 7'b0011_010);
        cycle(mk(4, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0), "l1 go", 2, 7'b1111_000);

        // Counter saturation on the 3-bit instance
        do_reset("sat");
        for (int c = 0; c < 10; c++)
            cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), "sat wait", 0, 7'b0);
        check("sat stall_cnt2", stall_cnt2, 7);
        check("sat stall_cnt", stall_cnt, 10);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), "sat dhit", 0, 7'b0);
        for (int c = 0; c < 10; c++)
            cycle(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), "sat jump", 0, 7'b0);
        check("sat flush_cnt2", flush_cnt2, 7);
        check("sat flush_cnt", flush_cnt, 10);
        check("sat stall_cnt2 held", stall_cnt2, 7);

        // Randomized traffic against the model
        do_reset("rnd");
        for (int n = 0; n < 2000; n++) begin
            v.src0    = 5'($urandom_range(0, 7));
            v.src1    = 5'($urandom_range(0, 7));
            v.used    = 2'($urandom_range(0, 3));
            v.long_rd = 5'($urandom_range(0, 7));
            v.lng     = ($urandom_range(0, 4) == 0);
            v.jump    = ($urandom_range(0, 9) == 0);
            v.idex_rt = 5'($urandom_range(0, 7));
            v.dren    = ($urandom_range(0, 2) == 0);
            v.br      = ($urandom_range(0, 9) == 0);
            v.ihit    = ($urandom_range(0, 9) < 7);
            v.mem_req = ($urandom_range(0, 3) == 0);
            v.dhit    = 1'($urandom_range(0, 1));
            cycle(v, $sformatf("rnd%0d", n), 0, 7'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
